imm_extend_unit: RTL and testbench
==================================

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, immediate field width; legal range 11..(OUT_W-1).
REQ-002 The block SHALL have parameter OUT_W, default 32, extended result width.
REQ-003 The block SHALL have parameter SHAMT_LO, default 6, LSB position of the shift-amount field inside i_num.
REQ-004 The block SHALL have parameter SHAMT_W, default 5, shift-amount field width; SHAMT_LO+SHAMT_W <= IN_W.
REQ-005 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-008 The block SHALL have port in_valid, input, 1, i_num/ExtSel valid this cycle.
REQ-009 The block SHALL have port in_ready, output, 1, block accepts an entry this cycle.
REQ-010 The block SHALL have port i_num, input, IN_W, raw immediate field.
REQ-011 The block SHALL have port ExtSel, input, 3, extension mode.
REQ-012 The block SHALL have port out_valid, output, 1, o_num/o_illegal hold a valid head entry.
REQ-013 The block SHALL have port out_ready, input, 1, consumer takes the head entry.
REQ-014 The block SHALL have port o_num, output, OUT_W, extended result of the head entry.
REQ-015 The block SHALL have port o_illegal, output, 1, head entry used an undefined ExtSel.

Function
REQ-016 The block SHALL compute the result at enqueue time from ExtSel: 000 zero-extended i_num[SHAMT_LO+SHAMT_W-1:SHAMT_LO]; 001 zero-extended i_num; 010 sign-extended i_num (replicate bit IN_W-1); 011 upper: i_num in bits [OUT_W-1:OUT_W-IN_W], zeros below; 100 sign-extended i_num[7:0].
REQ-017 For ExtSel 101, 110 and 111, the block SHALL store the 010 result and set the entry's o_illegal flag to 1; o_illegal SHALL be 0 for all other modes.
REQ-018 The block SHALL buffer entries in a 2-entry FIFO with an occupancy count of 0..2, in strict arrival order.
REQ-019 An enqueue SHALL occur when in_valid=1 and in_ready=1; a dequeue SHALL occur when out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL be 1 exactly when count<2, registered-state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 exactly when count>0, with no combinational path from in_valid.
REQ-022 Latency SHALL be 1 cycle: an entry enqueued at edge N SHALL appear on o_num/out_valid after edge N when it is the head.
REQ-023 With count=1, a simultaneous enqueue and dequeue SHALL leave count=1 with the new entry at the head.
REQ-024 With count=2, in_ready=0; a dequeue in that cycle SHALL reduce count to 1, and the input SHALL NOT be accepted that cycle.
REQ-025 A dequeue attempt with count=0 SHALL have no effect.
REQ-026 o_num and o_illegal SHALL be driven to 0 whenever out_valid=0.
REQ-027 flush=1 SHALL set count to 0 at the next edge, overriding any simultaneous enqueue or dequeue; that input entry SHALL be lost.
REQ-028 The head entry and count SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-030 Reset=0 SHALL immediately, independent of CLK, force count=0, pointers=0, out_valid=0, o_num=0, o_illegal=0 and in_ready=1.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered entries; no entry enqueued before reset SHALL ever appear on the output.
REQ-032 Reset release SHALL allow an enqueue at the first rising CLK edge at which Reset=1.

Verification
REQ-033 Mode sweep at defaults: i_num=16'h87C5, one entry per mode; outputs in order: 000 -> 32'h0000001F; 001 -> 32'h000087C5; 010 -> 32'hFFFF87C5; 011 -> 32'h87C50000; 100 -> 32'hFFFFFFC5; 111 -> 32'hFFFF87C5 with o_illegal=1.
REQ-034 Backpressure: out_ready=0, three back-to-back inputs 1,2,3 in mode 001 -> in_ready drops after the 2nd entry; 3 is held by the source; outputs drain in order 1,2,3 once out_ready=1.
REQ-035 Streaming: in_valid=out_ready=1 continuously for 10 entries -> count stays 1 and one result is output per cycle after a 1-cycle latency.
REQ-036 Flush with count=2 plus a simultaneous valid input -> next cycle out_valid=0, o_num=0, count=0; none of the three entries appear later.
REQ-037 Async reset pulse between edges with count=2 -> out_valid, o_num and o_illegal go to 0 before the next edge; after release, entry 16'h0001 in mode 010 -> 32'h00000001.
REQ-038 Parameter variant IN_W=12, OUT_W=24: i_num=12'h800, mode 010 -> 24'hFFF800; mode 011 -> 24'h800000.

Source files
------------

// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_unit
// Description : Immediate extender with a 2-entry result FIFO and
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_unit #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int SHAMT_LO = 6,
    parameter int SHAMT_W  = 5
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  i_num,
    input  logic [2:0]       ExtSel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] o_num,
    output logic             o_illegal
);

    localparam logic [2:0] c_sel_shamt = 3'b000;
    localparam logic [2:0] c_sel_zext  = 3'b001;
    localparam logic [2:0] c_sel_sext  = 3'b010;
    localparam logic [2:0] c_sel_upper = 3'b011;
    localparam logic [2:0] c_sel_sext8 = 3'b100;
    localparam logic [1:0] c_depth     = 2'd2;

    logic [OUT_W-1:0] r_data [2];
    logic             r_ill  [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic [OUT_W-1:0] w_ext;
    logic             w_ill;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    // Result is formed on the way in so the FIFO holds finished values.
    always_comb begin
        w_ext = {{(OUT_W-IN_W){i_num[IN_W-1]}}, i_num};
        w_ill = 1'b0;
        case (ExtSel)
            c_sel_shamt: w_ext = {{(OUT_W-SHAMT_W){1'b0}}, i_num[SHAMT_LO +: SHAMT_W]};
            c_sel_zext:  w_ext = {{(OUT_W-IN_W){1'b0}}, i_num};
            c_sel_sext:  w_ext = {{(OUT_W-IN_W){i_num[IN_W-1]}}, i_num};
            c_sel_upper: w_ext = {i_num, {(OUT_W-IN_W){1'b0}}};
            c_sel_sext8: w_ext = {{(OUT_W-8){i_num[7]}}, i_num[7:0]};
            default: begin
                w_ext = {{(OUT_W-IN_W){i_num[IN_W-1]}}, i_num};
                w_ill = 1'b1;
            end
        endcase
    end

    // Handshake flags depend only on registered occupancy.
    assign in_ready  = (r_count < c_depth);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (flush) begin
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                if (w_push) r_wptr <= ~r_wptr;
                if (w_pop)  r_rptr <= ~r_rptr;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_ill[0]  <= 1'b0;
            r_ill[1]  <= 1'b0;
        end else if (w_push && !flush) begin
            r_data[r_wptr] <= w_ext;
            r_ill[r_wptr]  <= w_ill;
        end
    end

    assign o_num     = out_valid ? r_data[r_rptr] : '0;
    assign o_illegal = out_valid ? r_ill[r_rptr]  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_unit
// Description : Directed self-checking bench for imm_extend_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] i_num = '0;
    logic [2:0]  ExtSel = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] o_num;
    logic        o_illegal;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [11:0] i_num2 = '0;
    logic [2:0]  ExtSel2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [23:0] o_num2;
    logic        o_illegal2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    imm_extend_unit dut (
        .CLK(CLK), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .i_num(i_num), .ExtSel(ExtSel),
        .out_valid(out_valid), .out_ready(out_ready), .o_num(o_num), .o_illegal(o_illegal)
    );

    imm_extend_unit #(.IN_W(12), .OUT_W(24)) dut_small (
        .CLK(CLK), .Reset(Reset), .flush(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .i_num(i_num2), .ExtSel(ExtSel2),
        .out_valid(out_valid2), .out_ready(out_ready2), .o_num(o_num2), .o_illegal(o_illegal2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] sweep_sel [6];
    logic [31:0] sweep_exp [6];

    initial begin
        sweep_sel[0] = 16'd0; sweep_exp[0] = 32'h0000001F;
        sweep_sel[1] = 16'd1; sweep_exp[1] = 32'h000087C5;
        sweep_sel[2] = 16'd2; sweep_exp[2] = 32'hFFFF87C5;
        sweep_sel[3] = 16'd3; sweep_exp[3] = 32'h87C50000;
        sweep_sel[4] = 16'd4; sweep_exp[4] = 32'hFFFFFFC5;
        sweep_sel[5] = 16'd7; sweep_exp[5] = 32'hFFFF87C5;

        // reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_o_num", o_num, 32'd0);
        chk("rst_o_illegal", {31'd0, o_illegal}, 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        // mode sweep
        out_ready = 1'b1;
        i_num = 16'h87C5;
        for (int m = 0; m < 6; m++) begin
            in_valid = 1'b1;
            ExtSel = sweep_sel[m][2:0];
            @(negedge CLK);
            in_valid = 1'b0;
            chk("sweep_valid", {31'd0, out_valid}, 32'd1);
            chk($sformatf("sweep_num_%0d", m), o_num, sweep_exp[m]);
            chk($sformatf("sweep_ill_%0d", m), {31'd0, o_illegal}, (m == 5) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        chk("sweep_empty", {31'd0, out_valid}, 32'd0);

        // backpressure
        out_ready = 1'b0;
        ExtSel = 3'b001;
        in_valid = 1'b1; i_num = 16'd1;
        @(negedge CLK);
        chk("bp_ready_c1", {31'd0, in_ready}, 32'd1);
        i_num = 16'd2;
        @(negedge CLK);
        chk("bp_ready_c2", {31'd0, in_ready}, 32'd0);
        chk("bp_head1", o_num, 32'd1);
        i_num = 16'd3;
        @(negedge CLK);
        chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_head", o_num, 32'd1);
        out_ready = 1'b1;
        @(negedge CLK);
        chk("bp_head2", o_num, 32'd2);
        chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("bp_head3", o_num, 32'd3);
        @(negedge CLK);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_drained_num", o_num, 32'd0);

        // streaming
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk("stream_ready", {31'd0, in_ready}, 32'd1);
                chk($sformatf("stream_num_%0d", k), o_num, 32'd100 + 32'(k) - 32'd1);
            end
            if (k < 10) begin
                in_valid = 1'b1;
                i_num = 16'd100 + 16'(k);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge CLK);
        end
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // flush with a full FIFO and a simultaneous input
        out_ready = 1'b0;
        in_valid = 1'b1; i_num = 16'hAAAA;
        @(negedge CLK);
        i_num = 16'hBBBB;
        @(negedge CLK);
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        i_num = 16'hCCCC; flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_num", o_num, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        chk("fl_nothing_later", {31'd0, out_valid}, 32'd0);

        // asynchronous reset between edges
        out_ready = 1'b0;
        in_valid = 1'b1; ExtSel = 3'b111; i_num = 16'h8123;
        @(negedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("ar_full_ill", {31'd0, o_illegal}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_num", o_num, 32'd0);
        chk("ar_ill", {31'd0, o_illegal}, 32'd0);
        chk("ar_ready", {31'd0, in_ready}, 32'd1);
        @(negedge CLK);
        Reset = 1'b1;
        in_valid = 1'b1; ExtSel = 3'b010; i_num = 16'h0001;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("ar_new_num", o_num, 32'h00000001);
        chk("ar_new_ill", {31'd0, o_illegal}, 32'd0);
        out_ready = 1'b1;
        @(negedge CLK);
        chk("ar_no_stale", {31'd0, out_valid}, 32'd0);

        // narrow parameter variant
        in_valid2 = 1'b1; ExtSel2 = 3'b010; i_num2 = 12'h800;
        @(negedge CLK);
        chk("p12_sext", {8'd0, o_num2}, 32'h00FFF800);
        ExtSel2 = 3'b011;
        @(negedge CLK);
        in_valid2 = 1'b0;
        chk("p12_upper", {8'd0, o_num2}, 32'h00800000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
